// File: rtl/gb_cpu_regfile_mp.sv
// Multi-port gameboy CPU register file: prioritised byte/pair writes, flag merge,
// TMP special ops, indexed reads, and a snapshot dump engine. Optional: GB_REGFILE_BYPASS_EN.
module gb_cpu_regfile_mp #(
  parameter int          NUM_WR   = 3,
  parameter int          NUM_RD   = 2,
  parameter logic [15:0] RESET_SP = 16'h0000,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR-1:0]    wr_wide,
  input  logic [4*NUM_WR-1:0]  wr_idx,
  input  logic [16*NUM_WR-1:0] wr_data,
  input  logic                 flag_en,
  input  logic [3:0]           flag_mask,
  input  logic [3:0]           flag_data,
  input  logic                 sext_tmp,
  input  logic                 sp_from_tmp,
  input  logic [4*NUM_RD-1:0]  rd_idx,
  output logic [8*NUM_RD-1:0]  rd_data,
  output logic [127:0]         regs,
  output logic                 wr_conflict,
  input  logic                 dump_start,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [3:0]           dump_idx,
  output logic [7:0]           dump_data,
  output logic                 dump_last,
  output logic                 dump_busy
);

  localparam int PW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  // Element i of the packed array lands at bits [8i+7:8i], matching the regs layout.
  localparam logic [127:0] RST_VAL = {32'h0, RESET_PC[7:0], RESET_PC[15:8],
                                      RESET_SP[7:0], RESET_SP[15:8], 64'h0};

  typedef struct packed {
    logic        en;
    logic        wide;
    logic [3:0]  idx;
    logic [15:0] data;
  } wr_req_t;

  typedef enum logic {D_IDLE, D_SEND} dstate_t;

  wr_req_t [NUM_WR-1:0]  wreq;
  logic [15:0][7:0]      regs_q, regs_d;
  logic [15:0]           upd;
  logic                  conflict_d, wr_conflict_q;

  for (genvar p = 0; p < NUM_WR; p++) begin : g_wreq
    assign wreq[p] = '{en: wr_en[p], wide: wr_wide[p],
                       idx: wr_idx[4*p +: 4], data: wr_data[16*p +: 16]};
  end

  always_comb begin
    regs_d     = regs_q;
    upd        = '0;
    conflict_d = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wreq[PW'(p)].en &&
            (wreq[PW'(p)].wide ? (wreq[PW'(p)].idx[3:1] == 3'(b >> 1))
                               : (wreq[PW'(p)].idx == 4'(b)))) begin
          if (upd[4'(b)]) conflict_d = 1'b1;
          else begin
            upd[4'(b)]    = 1'b1;
            regs_d[4'(b)] = (wreq[PW'(p)].wide && ((b & 1) == 0)) ? wreq[PW'(p)].data[15:8]
                                                                  : wreq[PW'(p)].data[7:0];
          end
        end
      end
    end
    if (!upd[1] && flag_en) begin
      upd[1]         = 1'b1;
      regs_d[1][7:4] = (regs_q[1][7:4] & ~flag_mask) | (flag_data & flag_mask);
    end
    // Special ops source pre-edge TMP, so SP takes the old TMP_H even alongside sext.
    if (!upd[12] && sext_tmp) begin
      upd[12]    = 1'b1;
      regs_d[12] = {8{regs_q[13][7]}};
    end
    if (sp_from_tmp) begin
      if (!upd[8]) begin upd[8] = 1'b1; regs_d[8] = regs_q[12]; end
      if (!upd[9]) begin upd[9] = 1'b1; regs_d[9] = regs_q[13]; end
    end
    if (upd[1]) regs_d[1][3:0] = 4'h0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q        <= RST_VAL;
      wr_conflict_q <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      wr_conflict_q <= conflict_d;
    end
  end

  assign regs        = regs_q;
  assign wr_conflict = wr_conflict_q;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [3:0] ri;
    assign ri = rd_idx[4*r +: 4];
`ifdef GB_REGFILE_BYPASS_EN
    assign rd_data[8*r +: 8] = regs_d[ri];
`else
    assign rd_data[8*r +: 8] = regs_q[ri];
`endif
  end

  // Dump engine streams a frozen copy so concurrent writes cannot tear the dump.
  dstate_t          state_q, state_d;
  logic [3:0]       didx_q, didx_d;
  logic [15:0][7:0] snap_q;
  logic             snap_ld;

  always_comb begin
    state_d    = state_q;
    didx_d     = didx_q;
    snap_ld    = 1'b0;
    dump_valid = 1'b0;
    dump_last  = 1'b0;
    dump_data  = 8'h00;
    case (state_q)
      D_IDLE: begin
        if (dump_start) begin
          snap_ld = 1'b1;
          state_d = D_SEND;
          didx_d  = 4'd0;
        end
      end
      D_SEND: begin
        dump_valid = 1'b1;
        dump_data  = snap_q[didx_q];
        dump_last  = (didx_q == 4'd15);
        if (dump_ready) begin
          if (didx_q == 4'd15) begin
            state_d = D_IDLE;
            didx_d  = 4'd0;
          end else begin
            didx_d = didx_q + 4'd1;
          end
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= D_IDLE;
      didx_q  <= 4'd0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      didx_q  <= didx_d;
      if (snap_ld) snap_q <= regs_q;
    end
  end

  assign dump_idx  = didx_q;
  assign dump_busy = (state_q != D_IDLE);

endmodule

// File: tb/tb_gb_cpu_regfile_mp.sv
// Directed bench for gb_cpu_regfile_mp: writes, priority, flags, TMP ops, dump and reset.
module tb_gb_cpu_regfile_mp;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   wr_en, wr_wide;
  logic [11:0]  wr_idx;
  logic [47:0]  wr_data;
  logic         flag_en;
  logic [3:0]   flag_mask, flag_data;
  logic         sext_tmp, sp_from_tmp;
  logic [7:0]   rd_idx;
  logic [15:0]  rd_data;
  logic [127:0] regs;
  logic         wr_conflict;
  logic         dump_start, dump_valid, dump_ready;
  logic [3:0]   dump_idx;
  logic [7:0]   dump_data;
  logic         dump_last, dump_busy;

  int n_chk  = 0;
  int n_fail = 0;

  gb_cpu_regfile_mp #(.NUM_WR(3), .NUM_RD(2), .RESET_SP(16'hFFFE), .RESET_PC(16'h0100)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_wide(wr_wide), .wr_idx(wr_idx),
    .wr_data(wr_data), .flag_en(flag_en), .flag_mask(flag_mask), .flag_data(flag_data),
    .sext_tmp(sext_tmp), .sp_from_tmp(sp_from_tmp), .rd_idx(rd_idx), .rd_data(rd_data),
    .regs(regs), .wr_conflict(wr_conflict), .dump_start(dump_start), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_last(dump_last), .dump_busy(dump_busy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_en = 3'b000; wr_wide = 3'b000; wr_idx = '0; wr_data = '0;
    flag_en = 1'b0; flag_mask = 4'h0; flag_data = 4'h0;
    sext_tmp = 1'b0; sp_from_tmp = 1'b0; dump_start = 1'b0;
  endtask

  function automatic logic [31:0] rg(input int i);
    return {24'h0, regs[8*i +: 8]};
  endfunction

  // Register contents just before the dump: A F B C D E H L SPH SPL PCH PCL TMPH TMPL IR IE
  logic [7:0] exp_snap [16] = '{8'h99, 8'hA0, 8'h12, 8'h00, 8'h11, 8'h00, 8'h12, 8'h55,
                                8'h00, 8'h80, 8'h01, 8'h00, 8'h3C, 8'h80, 8'h00, 8'h00};

  initial begin
    int cnt;
    idle_in();
    dump_ready = 1'b0;
    rd_idx = 8'h00;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      case (i)
        8:       check("rst_sph", rg(i), 32'hFF);
        9:       check("rst_spl", rg(i), 32'hFE);
        10:      check("rst_pch", rg(i), 32'h01);
        default: check("rst_reg", rg(i), 32'h00);
      endcase
    end
    check("rst_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_busy", {31'h0, dump_busy}, 32'h0);
    check("rst_conf", {31'h0, wr_conflict}, 32'h0);

    // Narrow B plus wide HL in one cycle
    wr_en = 3'b011; wr_wide = 3'b010;
    wr_idx = {4'h0, 4'h7, 4'h2}; wr_data = {16'h0, 16'hABCD, 16'h0012};
    rd_idx = {4'h7, 4'h2};
    #1;
`ifdef GB_REGFILE_BYPASS_EN
    check("rd_bypass", {16'h0, rd_data}, 32'hCD12);
`else
    check("rd_nobypass", {16'h0, rd_data}, 32'h0000);
`endif
    tick(); idle_in(); #1;
    check("wr_b", rg(2), 32'h12);
    check("wr_h", rg(6), 32'hAB);
    check("wr_l", rg(7), 32'hCD);
    check("rd_data", {16'h0, rd_data}, 32'hCD12);
    check("noconf", {31'h0, wr_conflict}, 32'h0);

    // Port0 and port2 both on D
    wr_en = 3'b101; wr_idx = {4'h4, 4'h0, 4'h4}; wr_data = {16'h0022, 16'h0, 16'h0011};
    tick(); idle_in(); #1;
    check("prio_d", rg(4), 32'h11);
    check("conf_pulse", {31'h0, wr_conflict}, 32'h1);
    tick();
    check("conf_clear", {31'h0, wr_conflict}, 32'h0);

    // Narrow L on port0 against wide HL on port1
    wr_en = 3'b011; wr_wide = 3'b010;
    wr_idx = {4'h0, 4'h6, 4'h7}; wr_data = {16'h0, 16'h1234, 16'h0055};
    tick(); idle_in(); #1;
    check("wide_conf_l", rg(7), 32'h55);
    check("wide_conf_h", rg(6), 32'h12);
    check("wide_conf", {31'h0, wr_conflict}, 32'h1);

    // Flag merge
    wr_en = 3'b001; wr_idx = 12'h001; wr_data = {32'h0, 16'h00F0};
    tick(); idle_in(); #1;
    check("f_set", rg(1), 32'hF0);
    flag_en = 1'b1; flag_mask = 4'b1010; flag_data = 4'b0000;
    tick(); idle_in(); #1;
    check("f_merge", rg(1), 32'h50);
    flag_en = 1'b1; flag_mask = 4'b1010; flag_data = 4'b0000;
    wr_en = 3'b010; wr_idx = 12'h010; wr_data = {16'h0, 16'h00FF, 16'h0};
    tick(); idle_in(); #1;
    check("f_port_wins", rg(1), 32'hF0);
    flag_en = 1'b1; flag_mask = 4'b0101; flag_data = 4'b0000;
    tick(); idle_in(); #1;
    check("f_merge2", rg(1), 32'hA0);

    // TMP special ops
    wr_en = 3'b001; wr_wide = 3'b001; wr_idx = 12'h00C; wr_data = {32'h0, 16'h0080};
    tick(); idle_in(); #1;
    check("tmp_l", rg(13), 32'h80);
    sext_tmp = 1'b1; sp_from_tmp = 1'b1;
    tick(); idle_in(); #1;
    check("sext_tmph", rg(12), 32'hFF);
    check("sp_h_old", rg(8), 32'h00);
    check("sp_l", rg(9), 32'h80);
    sext_tmp = 1'b1; wr_en = 3'b001; wr_idx = 12'h00C; wr_data = {32'h0, 16'h003C};
    tick(); idle_in(); #1;
    check("tmph_port_wins", rg(12), 32'h3C);

    // Dump with concurrent write and toggling ready
    wr_en = 3'b001; wr_idx = 12'h000; wr_data = {32'h0, 16'h0099};
    tick(); idle_in(); #1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    check("dump_busy", {31'h0, dump_busy}, 32'h1);
    check("dump_valid", {31'h0, dump_valid}, 32'h1);
    cnt = 0;
    for (int k = 0; k < 80 && cnt < 16; k++) begin
      if (k == 0) begin
        wr_en = 3'b001; wr_idx = 12'h000; wr_data = {32'h0, 16'h0077};
      end else wr_en = 3'b000;
      dump_start = (k == 3);
      dump_ready = ((k % 2) == 0);
      #1;
      if (dump_valid && dump_ready) begin
        check("dump_idx", {28'h0, dump_idx}, cnt);
        check("dump_data", {24'h0, dump_data}, {24'h0, exp_snap[cnt]});
        check("dump_last", {31'h0, dump_last}, {31'h0, cnt == 15});
        cnt++;
      end
      tick();
    end
    idle_in(); dump_ready = 1'b0; #1;
    check("dump_count", cnt, 32'd16);
    check("dump_end_valid", {31'h0, dump_valid}, 32'h0);
    check("dump_end_busy", {31'h0, dump_busy}, 32'h0);
    check("dump_end_idx", {28'h0, dump_idx}, 32'h0);
    check("a_after_dump", rg(0), 32'h77);

    // Reset in the middle of a dump
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0; dump_ready = 1'b1;
    for (int k = 0; k < 40 && dump_idx != 4'd5; k++) tick();
    check("mid_idx", {28'h0, dump_idx}, 32'h5);
    reset = 1'b1;
    tick();
    reset = 1'b0; dump_ready = 1'b0;
    check("rst_mid_valid", {31'h0, dump_valid}, 32'h0);
    check("rst_mid_busy", {31'h0, dump_busy}, 32'h0);
    check("rst_mid_a", rg(0), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
